// File: rtl/regfile_multiport.sv
// Multi-port register file: NUM_REGS x DATA_W, three combinational read ports, two write ports,
// and a per-register busy scoreboard. Define RF_BYPASS_EN to forward same-cycle writes to reads.
module regfile_multiport #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] SrcReg1,
    input  logic [ADDR_W-1:0] SrcReg2,
    input  logic [ADDR_W-1:0] SrcReg3,
    output logic [DATA_W-1:0] SrcData1,
    output logic [DATA_W-1:0] SrcData2,
    output logic [DATA_W-1:0] SrcData3,
    output logic              SrcBusy1,
    output logic              SrcBusy2,
    output logic              SrcBusy3,
    input  logic              WriteReg0,
    input  logic [ADDR_W-1:0] DstReg0,
    input  logic [DATA_W-1:0] DstData0,
    input  logic              WriteReg1,
    input  logic [ADDR_W-1:0] DstReg1,
    input  logic [DATA_W-1:0] DstData1,
    input  logic              Reserve,
    input  logic [ADDR_W-1:0] ResvReg
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;

    logic we0, we1, rsv;
    logic [ADDR_W-1:0] src_idx [3];
    logic [DATA_W-1:0] rd_data [3];
    logic              rd_busy [3];

    // Register 0 and indices beyond NUM_REGS are not backed by storage.
    function automatic logic idx_valid(input logic [ADDR_W-1:0] idx);
        return (idx != '0) && (32'(idx) < NUM_REGS);
    endfunction

    assign we0 = WriteReg0 && !rst && idx_valid(DstReg0);
    assign we1 = WriteReg1 && !rst && idx_valid(DstReg1);
    assign rsv = Reserve && !rst && idx_valid(ResvReg);

    // Port 0 applied first so port 1 wins a collision; reserve applied last so it beats release.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (we0 && DstReg0 == ADDR_W'(i)) begin
                regs_d[i] = DstData0;
                busy_d[i] = 1'b0;
            end
            if (we1 && DstReg1 == ADDR_W'(i)) begin
                regs_d[i] = DstData1;
                busy_d[i] = 1'b0;
            end
            if (rsv && ResvReg == ADDR_W'(i)) begin
                busy_d[i] = 1'b1;
            end
        end
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign src_idx[0] = SrcReg1;
    assign src_idx[1] = SrcReg2;
    assign src_idx[2] = SrcReg3;

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd_data[p] = '0;
            rd_busy[p] = 1'b0;
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (src_idx[p] == ADDR_W'(i)) begin
                    rd_data[p] = regs_q[i];
                    rd_busy[p] = busy_q[i];
                end
            end
`ifdef RF_BYPASS_EN
            // we0/we1 already exclude reset, index 0 and out-of-range targets.
            if (we1 && DstReg1 == src_idx[p]) begin
                rd_data[p] = DstData1;
                rd_busy[p] = 1'b0;
            end else if (we0 && DstReg0 == src_idx[p]) begin
                rd_data[p] = DstData0;
                rd_busy[p] = 1'b0;
            end
`endif
        end
    end

    assign SrcData1 = rd_data[0];
    assign SrcData2 = rd_data[1];
    assign SrcData3 = rd_data[2];
    assign SrcBusy1 = rd_busy[0];
    assign SrcBusy2 = rd_busy[1];
    assign SrcBusy3 = rd_busy[2];

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport: stimulus queues expected read data/busy per cycle,
// a negedge monitor pops and compares. Expectations follow RF_BYPASS_EN when it is defined.
module tb_regfile_multiport;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  SrcReg1, SrcReg2, SrcReg3;
    logic [15:0] SrcData1, SrcData2, SrcData3;
    logic        SrcBusy1, SrcBusy2, SrcBusy3;
    logic        WriteReg0, WriteReg1, Reserve;
    logic [3:0]  DstReg0, DstReg1, ResvReg;
    logic [15:0] DstData0, DstData1;

    typedef struct {
        string       name;
        logic [15:0] d1;
        logic [15:0] d2;
        logic [15:0] d3;
        logic [2:0]  b;
    } exp_t;

    exp_t exp_q [$];
    int   total = 0;
    int   bad   = 0;

`ifdef RF_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    regfile_multiport #(
        .DATA_W  (16),
        .ADDR_W  (4),
        .NUM_REGS(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .SrcReg1  (SrcReg1),
        .SrcReg2  (SrcReg2),
        .SrcReg3  (SrcReg3),
        .SrcData1 (SrcData1),
        .SrcData2 (SrcData2),
        .SrcData3 (SrcData3),
        .SrcBusy1 (SrcBusy1),
        .SrcBusy2 (SrcBusy2),
        .SrcBusy3 (SrcBusy3),
        .WriteReg0(WriteReg0),
        .DstReg0  (DstReg0),
        .DstData0 (DstData0),
        .WriteReg1(WriteReg1),
        .DstReg1  (DstReg1),
        .DstData1 (DstData1),
        .Reserve  (Reserve),
        .ResvReg  (ResvReg)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if ({SrcData1, SrcData2, SrcData3, SrcBusy1, SrcBusy2, SrcBusy3} !==
                {e.d1, e.d2, e.d3, e.b}) begin
                bad++;
                $display("FAIL %s: got data=%h/%h/%h busy=%b%b%b, want data=%h/%h/%h busy=%b",
                         e.name, SrcData1, SrcData2, SrcData3, SrcBusy1, SrcBusy2, SrcBusy3,
                         e.d1, e.d2, e.d3, e.b);
            end
        end
    end

    task automatic idle();
        rst = 1'b0;
        SrcReg1 = 4'd0; SrcReg2 = 4'd0; SrcReg3 = 4'd0;
        WriteReg0 = 1'b0; DstReg0 = 4'd0; DstData0 = 16'h0;
        WriteReg1 = 1'b0; DstReg1 = 4'd0; DstData1 = 16'h0;
        Reserve = 1'b0; ResvReg = 4'd0;
    endtask

    task automatic rd(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3);
        SrcReg1 = a1; SrcReg2 = a2; SrcReg3 = a3;
    endtask

    // Queue the expectation for the current cycle, then advance past the next edge.
    task automatic tick(input string nm, input logic [15:0] e1, input logic [15:0] e2,
                        input logic [15:0] e3, input logic [2:0] eb);
        exp_t e;
        e.name = nm; e.d1 = e1; e.d2 = e2; e.d3 = e3; e.b = eb;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        rd(4'd1, 4'd2, 4'd3);
        @(posedge clk);
        #1;
        idle();

        rd(4'd1, 4'd2, 4'd3);
        tick("reset", 16'h0, 16'h0, 16'h0, 3'b000);

        rd(4'd1, 4'd2, 4'd0);
        WriteReg0 = 1'b1; DstReg0 = 4'd1; DstData0 = 16'h0101;
        WriteReg1 = 1'b1; DstReg1 = 4'd2; DstData1 = 16'h1010;
        tick("dual_write_cyc", Byp ? 16'h0101 : 16'h0, Byp ? 16'h1010 : 16'h0, 16'h0, 3'b000);

        rd(4'd1, 4'd2, 4'd0);
        tick("dual_write_next", 16'h0101, 16'h1010, 16'h0, 3'b000);

        rd(4'd5, 4'd5, 4'd5);
        WriteReg0 = 1'b1; DstReg0 = 4'd5; DstData0 = 16'hAAAA;
        WriteReg1 = 1'b1; DstReg1 = 4'd5; DstData1 = 16'h5555;
        tick("collide_cyc", Byp ? 16'h5555 : 16'h0, Byp ? 16'h5555 : 16'h0,
             Byp ? 16'h5555 : 16'h0, 3'b000);

        rd(4'd5, 4'd0, 4'd1);
        tick("collide_next", 16'h5555, 16'h0, 16'h0101, 3'b000);

        rd(4'd3, 4'd1, 4'd2);
        WriteReg0 = 1'b1; DstReg0 = 4'd3; DstData0 = 16'h00AA;
        tick("r3_same_cyc", Byp ? 16'h00AA : 16'h0, 16'h0101, 16'h1010, 3'b000);

        rd(4'd3, 4'd3, 4'd3);
        tick("r3_next", 16'h00AA, 16'h00AA, 16'h00AA, 3'b000);

        rd(4'd0, 4'd0, 4'd0);
        WriteReg0 = 1'b1; DstReg0 = 4'd0; DstData0 = 16'hBEEF;
        Reserve = 1'b1; ResvReg = 4'd0;
        tick("r0_write_cyc", 16'h0, 16'h0, 16'h0, 3'b000);

        rd(4'd0, 4'd8, 4'd0);
        WriteReg1 = 1'b1; DstReg1 = 4'd8; DstData1 = 16'hABCD;
        tick("r0_next_r8_cyc", 16'h0, Byp ? 16'hABCD : 16'h0, 16'h0, 3'b000);

        rd(4'd0, 4'd8, 4'd8);
        tick("r8_next", 16'h0, 16'hABCD, 16'hABCD, 3'b000);

        rd(4'd4, 4'd4, 4'd4);
        Reserve = 1'b1; ResvReg = 4'd4;
        tick("resv_cyc", 16'h0, 16'h0, 16'h0, 3'b000);

        rd(4'd4, 4'd4, 4'd1);
        WriteReg0 = 1'b1; DstReg0 = 4'd4; DstData0 = 16'h1234;
        Reserve = 1'b1; ResvReg = 4'd4;
        tick("wr_resv_cyc", Byp ? 16'h1234 : 16'h0, Byp ? 16'h1234 : 16'h0, 16'h0101,
             Byp ? 3'b000 : 3'b110);

        rd(4'd4, 4'd4, 4'd4);
        tick("wr_resv_next", 16'h1234, 16'h1234, 16'h1234, 3'b111);

        rd(4'd4, 4'd2, 4'd4);
        WriteReg1 = 1'b1; DstReg1 = 4'd4; DstData1 = 16'h5678;
        tick("release_cyc", Byp ? 16'h5678 : 16'h1234, 16'h1010, Byp ? 16'h5678 : 16'h1234,
             Byp ? 3'b000 : 3'b101);

        rd(4'd4, 4'd4, 4'd4);
        tick("release_next", 16'h5678, 16'h5678, 16'h5678, 3'b000);

        rd(4'd6, 4'd6, 4'd6);
        Reserve = 1'b1; ResvReg = 4'd6;
        tick("resv6_cyc", 16'h0, 16'h0, 16'h0, 3'b000);

        // Reset cycle: write is discarded, no bypass, outputs still show stored state.
        rd(4'd6, 4'd5, 4'd6);
        rst = 1'b1;
        WriteReg0 = 1'b1; DstReg0 = 4'd6; DstData0 = 16'hFFFF;
        Reserve = 1'b1; ResvReg = 4'd6;
        tick("rst_cyc", 16'h0, 16'h5555, 16'h0, 3'b101);

        rd(4'd6, 4'd5, 4'd4);
        tick("rst_clears", 16'h0, 16'h0, 16'h0, 3'b000);

        rd(4'd1, 4'd8, 4'd3);
        tick("rst_clears_all", 16'h0, 16'h0, 16'h0, 3'b000);

        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
